// File: rtl/taxi_axi_ram_sp_ctrl_if.sv
// AXI4 bundle carrying the write (AW/W/B) and read (AR/R) channels, with
// slave-side modports for each direction.
interface taxi_axi_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int STRB_W = DATA_W / 8,
    parameter int ID_W   = 8
) ();
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport wr_slv (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport rd_slv (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/taxi_axi_ram_sp_ctrl.sv
// AXI4 slave over a single-port RAM: whole bursts are granted round-robin
// between the write and read channels, one RAM access per cycle.
module taxi_axi_ram_sp_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    taxi_axi_if.wr_slv s_axi_wr,
    taxi_axi_if.rd_slv s_axi_rd
);
    localparam int DATA_W = s_axi_wr.DATA_W;
    localparam int STRB_W = DATA_W / 8;
    localparam int ID_W   = s_axi_wr.ID_W;
    localparam int LSB    = $clog2(STRB_W);
    localparam int WORDS  = 2 ** (ADDR_W - LSB);

    typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_BURST} state_t;
    typedef enum logic {GRANT_RD, GRANT_WR} grant_t;

    state_t            state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic              issue_done_q, issue_done_d;
    logic              awready_q, awready_d;
    logic              arready_q, arready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem [WORDS];

    logic              wr_en;
    logic              rd_issue;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] addr_next;
    logic              unused_sig;

    assign unused_sig = ^{s_axi_wr.awaddr, s_axi_rd.araddr, s_axi_wr.wlast};

    always_comb begin
        step      = ADDR_W'(1) << size_q;
        wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
        case (burst_q)
            2'b00:   addr_next = addr_q;
            2'b10:   addr_next = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
            default: addr_next = addr_q + step;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        size_d       = size_q;
        burst_d      = burst_q;
        issue_done_d = issue_done_q;
        awready_d    = awready_q;
        arready_d    = arready_q;
        wready_d     = wready_q;
        bvalid_d     = bvalid_q;
        bid_d        = bid_q;
        rvalid_d     = rvalid_q;
        rlast_d      = rlast_q;
        rid_d        = rid_q;
        wr_en        = 1'b0;
        rd_issue     = 1'b0;
        case (state_q)
            IDLE: begin
                // A granted ready is held one cycle; the handshake completes while it is high.
                if (awready_q) begin
                    awready_d = 1'b0;
                    if (s_axi_wr.awvalid) begin
                        id_d     = s_axi_wr.awid;
                        addr_d   = s_axi_wr.awaddr[ADDR_W-1:0];
                        len_d    = s_axi_wr.awlen;
                        size_d   = s_axi_wr.awsize;
                        burst_d  = s_axi_wr.awburst;
                        cnt_d    = '0;
                        wready_d = 1'b1;
                        state_d  = WR_DATA;
                    end
                end else if (arready_q) begin
                    arready_d = 1'b0;
                    if (s_axi_rd.arvalid) begin
                        id_d         = s_axi_rd.arid;
                        addr_d       = s_axi_rd.araddr[ADDR_W-1:0];
                        len_d        = s_axi_rd.arlen;
                        size_d       = s_axi_rd.arsize;
                        burst_d      = s_axi_rd.arburst;
                        cnt_d        = '0;
                        issue_done_d = 1'b0;
                        state_d      = RD_BURST;
                    end
                end else if (s_axi_wr.awvalid && (!s_axi_rd.arvalid || last_grant_q == GRANT_RD)) begin
                    awready_d    = 1'b1;
                    last_grant_d = GRANT_WR;
                end else if (s_axi_rd.arvalid) begin
                    arready_d    = 1'b1;
                    last_grant_d = GRANT_RD;
                end
            end
            WR_DATA: begin
                if (s_axi_wr.wvalid && wready_q) begin
                    wr_en  = 1'b1;
                    addr_d = addr_next;
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == len_q) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bid_d    = id_q;
                        state_d  = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (s_axi_wr.bready) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            RD_BURST: begin
                if (rvalid_q && s_axi_rd.rready) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                end
                // Issue only when the output register is free this cycle.
                if (!issue_done_q && (!rvalid_q || s_axi_rd.rready)) begin
                    rd_issue = 1'b1;
                    rvalid_d = 1'b1;
                    rlast_d  = (cnt_q == len_q);
                    rid_d    = id_q;
                    addr_d   = addr_next;
                    cnt_d    = cnt_q + 8'd1;
                    if (cnt_q == len_q) begin
                        issue_done_d = 1'b1;
                    end
                end else if (rvalid_q && s_axi_rd.rready && rlast_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_RD;
            id_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            issue_done_q <= 1'b0;
            awready_q    <= 1'b0;
            arready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bid_q        <= '0;
            rvalid_q     <= 1'b0;
            rlast_q      <= 1'b0;
            rid_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            size_q       <= size_d;
            burst_q      <= burst_d;
            issue_done_q <= issue_done_d;
            awready_q    <= awready_d;
            arready_q    <= arready_d;
            wready_q     <= wready_d;
            bvalid_q     <= bvalid_d;
            bid_q        <= bid_d;
            rvalid_q     <= rvalid_d;
            rlast_q      <= rlast_d;
            rid_q        <= rid_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_issue) begin
            rdata_q <= mem[addr_q[ADDR_W-1:LSB]];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (s_axi_wr.wstrb[i]) begin
                    mem[addr_q[ADDR_W-1:LSB]][i*8 +: 8] <= s_axi_wr.wdata[i*8 +: 8];
                end
            end
        end
    end

    assign s_axi_wr.awready = awready_q;
    assign s_axi_wr.wready  = wready_q;
    assign s_axi_wr.bvalid  = bvalid_q;
    assign s_axi_wr.bid     = bid_q;
    assign s_axi_wr.bresp   = 2'b00;
    assign s_axi_rd.arready = arready_q;
    assign s_axi_rd.rvalid  = rvalid_q;
    assign s_axi_rd.rdata   = rdata_q;
    assign s_axi_rd.rlast   = rlast_q;
    assign s_axi_rd.rid     = rid_q;
    assign s_axi_rd.rresp   = 2'b00;
endmodule

// File: tb/tb_taxi_axi_ram_sp_ctrl.sv
// Directed bench for the shared single-port AXI RAM: reset state, arbitration,
// INCR/WRAP bursts, byte strobes, read backpressure and mid-burst reset.
module tb_taxi_axi_ram_sp_ctrl;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    logic [31:0] wr_data [16];
    logic [31:0] rd_data [16];
    bit          rd_last [16];
    int          rd_cyc  [16];
    logic [7:0]  rd_id;
    logic [1:0]  rd_resp;

    bit         mon_en;
    int         grant_cnt;
    logic [7:0] grant_log [8];
    bit         both_hi;

    taxi_axi_if #(.DATA_W(32), .ADDR_W(32), .ID_W(8)) bus ();

    taxi_axi_ram_sp_ctrl #(.ADDR_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_axi_wr (bus),
        .s_axi_rd (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.awvalid && bus.awready) begin
                if (grant_cnt < 8) grant_log[grant_cnt] = "W";
                grant_cnt++;
            end
            if (bus.arvalid && bus.arready) begin
                if (grant_cnt < 8) grant_log[grant_cnt] = "R";
                grant_cnt++;
            end
            if (bus.awready && bus.arready) both_hi = 1'b1;
        end
    end

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [7:0] id, input logic [3:0] strb,
                             input bit do_b, output logic [7:0] bid, output logic [1:0] bresp, output bit ok);
        int n;
        ok = 1'b1;
        bid = '0;
        bresp = '0;
        bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst; bus.awid = id;
        bus.awvalid = 1'b1;
        n = 0;
        while (bus.awready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) begin ok = 1'b0; bus.awvalid = 1'b0; return; end
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.wdata = wr_data[i]; bus.wstrb = strb; bus.wlast = (i == int'(len)); bus.wvalid = 1'b1;
            n = 0;
            while (bus.wready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
            if (n >= 50) begin ok = 1'b0; bus.wvalid = 1'b0; return; end
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b0;
        bus.wlast = 1'b0;
        bus.bready = do_b;
        n = 0;
        while (bus.bvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) begin ok = 1'b0; bus.bready = 1'b0; return; end
        bid = bus.bid;
        bresp = bus.bresp;
        if (do_b) begin
            @(posedge clk); #1;
            bus.bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [7:0] id, input bit bp,
                            output int beats, output int lat_first, output bit ok, output bit stable);
        int n, lat, k;
        bit done, have_prev, rr;
        logic [31:0] prev_data;
        logic prev_last;
        ok = 1'b1; stable = 1'b1; beats = 0; lat_first = -1;
        bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst; bus.arid = id;
        bus.arvalid = 1'b1;
        n = 0;
        while (bus.arready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) begin ok = 1'b0; bus.arvalid = 1'b0; return; end
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        lat = 1; k = 0; done = 1'b0; have_prev = 1'b0; prev_data = '0; prev_last = 1'b0;
        while (!done && lat < 200) begin
            rr = bp ? (k % 3 == 0) : 1'b1;
            k++;
            bus.rready = rr;
            if (have_prev && (bus.rvalid !== 1'b1 || bus.rdata !== prev_data || bus.rlast !== prev_last))
                stable = 1'b0;
            if (bus.rvalid === 1'b1) begin
                if (lat_first < 0) lat_first = lat;
                if (rr && beats < 16) begin
                    rd_data[beats] = bus.rdata; rd_last[beats] = bus.rlast; rd_cyc[beats] = lat;
                    rd_id = bus.rid; rd_resp = bus.rresp;
                    beats++;
                    if (bus.rlast === 1'b1) done = 1'b1;
                end
            end
            have_prev = (bus.rvalid === 1'b1) && !rr;
            prev_data = bus.rdata;
            prev_last = bus.rlast;
            @(posedge clk); #1;
            lat++;
        end
        bus.rready = 1'b0;
        if (!done) ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0)
            $display("FAIL reset_ready_valid got=%b exp=00000", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
        else pass_cnt++;
        total_cnt++;
        if ({bus.bresp, bus.rresp, bus.rlast} !== 5'b0)
            $display("FAIL reset_resp_last got=%b exp=00000", {bus.bresp, bus.rresp, bus.rlast});
        else pass_cnt++;
        total_cnt++;
        if ({bus.bid, bus.rid} !== 16'h0) $display("FAIL reset_ids got=%h exp=0000", {bus.bid, bus.rid});
        else pass_cnt++;
        total_cnt++;
        if (bus.rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=00000000", bus.rdata);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_arbitration();
        logic [7:0] bid1, bid2;
        logic [1:0] br;
        bit wok1, wok2, rok1, rok2, st;
        int bt, lt;
        logic [31:0] r1;
        grant_cnt = 0; both_hi = 1'b0; mon_en = 1'b1;
        fork
            begin
                wr_data[0] = 32'hCAFE_0001;
                axi_write(32'h200, 8'd0, 3'd2, 2'd1, 8'h01, 4'hF, 1'b1, bid1, br, wok1);
                wr_data[0] = 32'hCAFE_0002;
                axi_write(32'h204, 8'd0, 3'd2, 2'd1, 8'h02, 4'hF, 1'b1, bid2, br, wok2);
            end
            begin
                axi_read(32'h200, 8'd0, 3'd2, 2'd1, 8'h03, 1'b0, bt, lt, rok1, st);
                r1 = rd_data[0];
                axi_read(32'h204, 8'd0, 3'd2, 2'd1, 8'h04, 1'b0, bt, lt, rok2, st);
            end
        join
        @(posedge clk); #1;
        mon_en = 1'b0;
        total_cnt++;
        if (!(wok1 && wok2 && rok1 && rok2)) $display("FAIL arb_complete got=%b exp=1111", {wok1, wok2, rok1, rok2});
        else pass_cnt++;
        total_cnt++;
        if (grant_cnt != 4) $display("FAIL arb_grant_count got=%0d exp=4", grant_cnt);
        else pass_cnt++;
        total_cnt++;
        if ({grant_log[0], grant_log[1], grant_log[2], grant_log[3]} !== "WRWR")
            $display("FAIL arb_order got=%s exp=WRWR", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]});
        else pass_cnt++;
        total_cnt++;
        if (both_hi) $display("FAIL arb_both_ready got=1 exp=0");
        else pass_cnt++;
        total_cnt++;
        if (r1 !== 32'hCAFE_0001) $display("FAIL arb_read_after_write got=%h exp=cafe0001", r1);
        else pass_cnt++;
        total_cnt++;
        if (rd_data[0] !== 32'hCAFE_0002) $display("FAIL arb_read2 got=%h exp=cafe0002", rd_data[0]);
        else pass_cnt++;
    endtask

    task automatic test_single();
        logic [7:0] bid;
        logic [1:0] br;
        bit ok, st;
        int bt, lt;
        wr_data[0] = 32'hDEAD_BEEF;
        axi_write(32'h0010, 8'd0, 3'd2, 2'd1, 8'h5A, 4'hF, 1'b1, bid, br, ok);
        total_cnt++;
        if (!ok || bid !== 8'h5A || br !== 2'b00) $display("FAIL single_bresp got=ok%0b id=%h resp=%0d exp=ok1 id=5a resp=0", ok, bid, br);
        else pass_cnt++;
        axi_read(32'h0010, 8'd0, 3'd2, 2'd1, 8'h33, 1'b0, bt, lt, ok, st);
        total_cnt++;
        if (!ok || bt != 1) $display("FAIL single_beats got=ok%0b beats=%0d exp=ok1 beats=1", ok, bt);
        else pass_cnt++;
        total_cnt++;
        if (rd_data[0] !== 32'hDEAD_BEEF) $display("FAIL single_rdata got=%h exp=deadbeef", rd_data[0]);
        else pass_cnt++;
        total_cnt++;
        if (rd_last[0] !== 1'b1 || rd_id !== 8'h33 || rd_resp !== 2'b00)
            $display("FAIL single_rfields got=last%0b id=%h resp=%0d exp=last1 id=33 resp=0", rd_last[0], rd_id, rd_resp);
        else pass_cnt++;
        total_cnt++;
        if (lt != 2) $display("FAIL single_latency got=%0d exp=2", lt);
        else pass_cnt++;
    endtask

    task automatic test_incr_burst();
        logic [7:0] bid;
        logic [1:0] br;
        bit ok, st;
        int bt, lt;
        for (int i = 0; i < 8; i++) wr_data[i] = i;
        axi_write(32'h0100, 8'd7, 3'd2, 2'd1, 8'h11, 4'hF, 1'b1, bid, br, ok);
        total_cnt++;
        if (!ok || bid !== 8'h11) $display("FAIL incr_write got=ok%0b id=%h exp=ok1 id=11", ok, bid);
        else pass_cnt++;
        axi_read(32'h0100, 8'd7, 3'd2, 2'd1, 8'h12, 1'b0, bt, lt, ok, st);
        total_cnt++;
        if (!ok || bt != 8) $display("FAIL incr_beats got=ok%0b beats=%0d exp=ok1 beats=8", ok, bt);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if (rd_data[i] !== 32'(i) || rd_last[i] !== (i == 7) || rd_cyc[i] != 2 + i)
                $display("FAIL incr_beat%0d got=data%h last%0b cyc%0d exp=data%h last%0b cyc%0d",
                         i, rd_data[i], rd_last[i], rd_cyc[i], 32'(i), (i == 7), 2 + i);
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        logic [7:0] bid;
        logic [1:0] br;
        bit ok, st;
        int bt, lt;
        logic [31:0] exp_d [4];
        exp_d = '{32'hA2, 32'hA3, 32'hA0, 32'hA1};
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hA0 + 32'(i);
        axi_write(32'h0100, 8'd3, 3'd2, 2'd1, 8'h21, 4'hF, 1'b1, bid, br, ok);
        axi_read(32'h0108, 8'd3, 3'd2, 2'd2, 8'h22, 1'b0, bt, lt, ok, st);
        total_cnt++;
        if (!ok || bt != 4 || rd_last[3] !== 1'b1) $display("FAIL wrap_beats got=ok%0b beats=%0d last%0b exp=ok1 beats=4 last1", ok, bt, rd_last[3]);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (rd_data[i] !== exp_d[i]) $display("FAIL wrap_beat%0d got=%h exp=%h", i, rd_data[i], exp_d[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_strobe();
        logic [7:0] bid;
        logic [1:0] br;
        bit ok, st;
        int bt, lt;
        wr_data[0] = 32'hFFFF_FFFF;
        axi_write(32'h0020, 8'd0, 3'd2, 2'd1, 8'h31, 4'hF, 1'b1, bid, br, ok);
        wr_data[0] = 32'h1122_3344;
        axi_write(32'h0020, 8'd0, 3'd2, 2'd1, 8'h32, 4'h5, 1'b1, bid, br, ok);
        axi_read(32'h0020, 8'd0, 3'd2, 2'd1, 8'h33, 1'b0, bt, lt, ok, st);
        total_cnt++;
        if (!ok || rd_data[0] !== 32'hFF22_FF44) $display("FAIL strobe_merge got=%h exp=ff22ff44", rd_data[0]);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bit ok, st;
        int bt, lt;
        axi_read(32'h0100, 8'd3, 3'd2, 2'd1, 8'h41, 1'b1, bt, lt, ok, st);
        total_cnt++;
        if (!ok || bt != 4 || rd_last[3] !== 1'b1) $display("FAIL bp_beats got=ok%0b beats=%0d exp=ok1 beats=4", ok, bt);
        else pass_cnt++;
        total_cnt++;
        if (!st) $display("FAIL bp_stable got=0 exp=1");
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (rd_data[i] !== 32'hA0 + 32'(i)) $display("FAIL bp_beat%0d got=%h exp=%h", i, rd_data[i], 32'hA0 + 32'(i));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] bid;
        logic [1:0] br;
        bit ok, st;
        int bt, lt, n;
        wr_data[0] = 32'h5555_5555;
        axi_write(32'h0040, 8'd0, 3'd2, 2'd1, 8'h07, 4'hF, 1'b0, bid, br, ok);
        total_cnt++;
        if (!ok) $display("FAIL rst_bvalid_seen got=0 exp=1");
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (bus.bvalid !== 1'b0) $display("FAIL rst_bvalid_drop got=%b exp=0", bus.bvalid);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.araddr = 32'h0100; bus.arlen = 8'd7; bus.arsize = 3'd2; bus.arburst = 2'd1; bus.arid = 8'h09;
        bus.rready = 1'b0;
        bus.arvalid = 1'b1;
        n = 0;
        while (bus.arready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        n = 0;
        while (bus.rvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        total_cnt++;
        if (bus.rvalid !== 1'b1) $display("FAIL rst_rvalid_seen got=%b exp=1", bus.rvalid);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b0) $display("FAIL rst_rvalid_drop got=%b%b exp=00", bus.rvalid, bus.arready);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        wr_data[0] = 32'h0BAD_F00D;
        axi_write(32'h0030, 8'd0, 3'd2, 2'd1, 8'h44, 4'hF, 1'b1, bid, br, ok);
        total_cnt++;
        if (!ok || bid !== 8'h44 || br !== 2'b00) $display("FAIL rst_next_aw got=ok%0b id=%h exp=ok1 id=44", ok, bid);
        else pass_cnt++;
        axi_read(32'h0010, 8'd0, 3'd2, 2'd1, 8'h45, 1'b0, bt, lt, ok, st);
        total_cnt++;
        if (!ok || rd_data[0] !== 32'hDEAD_BEEF) $display("FAIL rst_ram_kept got=%h exp=deadbeef", rd_data[0]);
        else pass_cnt++;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        pass_cnt = 0; total_cnt = 0;
        mon_en = 1'b0; grant_cnt = 0; both_hi = 1'b0;
        for (int i = 0; i < 8; i++) grant_log[i] = " ";
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        test_reset();
        test_arbitration();
        test_single();
        test_incr_burst();
        test_wrap();
        test_strobe();
        test_backpressure();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
